pdm_dac_multi: RTL and testbench
================================

Name: pdm_dac_multi

Overview:
Multi-channel audio DAC modulator, parametrised successor to the single-channel accumulator PWM output stage.
- Accepts sample frames (one word per channel) over a valid/ready stream into a frame FIFO.
- Pops one frame per internal sample tick and drives one 1-bit output per channel to the external analog RC filters.
- Runtime mode select between first-order delta-sigma (PDM) and classic counter-compare PWM; sticky underrun status for the bus-side controller.

Parameters:
DATA_W, 24, sample width per channel (unsigned, offset-binary)
CHANNELS, 2, number of independent output channels
FIFO_DEPTH, 4, frame FIFO depth (power of two, >=2)
SAMPLE_DIV, 256, clk cycles per sample tick (>=2)
PWM_W, 8, counter width in PWM mode (<= DATA_W)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
enable  in  1  1 = run modulators and tick divider; 0 = outputs idle
mode  in  1  0 = delta-sigma, 1 = PWM; sampled only while enable=0
wr_valid  in  1  frame write request
wr_ready  out  1  FIFO can accept a frame (= !full)
wr_data  in  CHANNELS*DATA_W  frame; channel k at bits [k*DATA_W +: DATA_W]
clr_status  in  1  clears sticky underrun
pdm_out  out  CHANNELS  modulated 1-bit outputs, registered
sample_tick  out  1  one-cycle pulse on each tick
fifo_level  out  clog2(FIFO_DEPTH)+1  frames stored
underrun  out  1  sticky: tick occurred with FIFO empty
busy  out  1  enable=1 and a frame has been loaded since enable rose

Behaviour:
- Reset: pdm_out=0, sample_tick=0, fifo_level=0, underrun=0, busy=0, wr_ready=1.
  - Accumulators, PWM counter, divider and holding registers cleared; FIFO emptied; latched mode=0.
  - Reset mid-frame discards all FIFO contents.
- Write handshake:
  - A frame is pushed when wr_valid && wr_ready at a clk edge.
  - wr_ready = (fifo_level != FIFO_DEPTH), computed from registered level.
  - No push when full; wr_valid held while full simply waits.
  - Writes are accepted regardless of enable.
- Mode latch: mode is copied into an internal register every cycle enable=0; it is frozen while enable=1.
- Tick divider:
  - Counts 0..SAMPLE_DIV-1 while enable=1; held at 0 while enable=0.
  - sample_tick=1 for the cycle in which the count equals SAMPLE_DIV-1.
  - The first tick occurs SAMPLE_DIV cycles after enable rises.
- Pop:
  - On a tick with level>0, the head frame loads the per-channel holding registers at that edge and level decrements.
  - On a tick with level=0, the holding registers keep their previous value and underrun is set.
  - Same-cycle push + pop: level unchanged. With FIFO empty, the pop happens first, so underrun is set and the pushed frame is stored.
  - clr_status and underrun set in the same cycle: set wins.
- Delta-sigma mode, per channel, each cycle enable=1:
  - sum = {1'b0, acc[DATA_W-1:0]} + {1'b0, hold}, width DATA_W+1.
  - acc <= sum[DATA_W-1:0]; pdm_out[k] <= sum[DATA_W].
  - Ones density = hold / 2^DATA_W.
  - A new holding value affects pdm_out from the edge after the load (2 cycles after the tick cycle).
- PWM mode:
  - A shared counter cnt[PWM_W-1:0] increments every cycle enable=1 and wraps modulo 2^PWM_W.
  - pdm_out[k] <= (cnt < hold[DATA_W-1 -: PWM_W]).
  - Duty is top-bits / 2^PWM_W; all-zero top bits give a constant 0; the maximum value gives 2^PWM_W - 1 highs per period.
- enable=0:
  - pdm_out forced to 0 next edge.
  - Accumulators and counter cleared; holding registers cleared; busy=0.
  - FIFO and underrun retained.
- Channels are fully independent apart from the shared tick and PWM counter.

Test Plan:
All scenarios use DATA_W=24, CHANNELS=2, FIFO_DEPTH=4, SAMPLE_DIV=16, PWM_W=4.
- Reset state: reset asserted 3 cycles -> pdm_out=0, fifo_level=0, wr_ready=1, underrun=0.
- Delta-sigma density:
  - Stimulus: push frame ch0=0x800000, ch1=0x400000, then enable=1; push 3 identical frames.
  - After the first tick, ch0 must give exactly 8 ones in any 16 consecutive cycles (alternating); ch1 must give 4 ones per 16.
- PWM mode: with mode=1 latched, frame ch0=0x400000, ch1=0x000000 -> ch0 high 4 of every 16 cycles, ch1 constant 0; changing mode while enabled has no effect.
- FIFO full/backpressure: enable=0, push 5 frames with wr_valid held -> 4 accepted, fifo_level=4, wr_ready=0. After enable=1 and the first tick -> level=3, wr_ready=1.
- Underrun: one frame queued, run 3 ticks -> underrun=1 at 2nd tick, outputs keep the last sample. clr_status pulse -> underrun=0. clr_status coincident with another empty tick -> underrun stays 1.
- Reset mid-operation: reset while 3 frames queued and outputs toggling -> next cycle level=0, pdm_out=0, underrun=0; a fresh frame plays correctly after enable.

Source files
------------

// File: rtl/pdm_dac_multi.sv
// Multi-channel audio DAC modulator: frame FIFO feeding per-channel
// first-order delta-sigma (PDM) or counter-compare PWM 1-bit outputs.
// Ports:
//   clk, reset      - system clock, synchronous active-high reset
//   enable, mode    - run control; mode (0=PDM, 1=PWM) latched while idle
//   wr_valid/ready  - frame write handshake, wr_data holds all channels
//   clr_status      - clears sticky underrun
//   pdm_out         - registered 1-bit outputs, one per channel
//   sample_tick     - one-cycle pulse per sample period
//   fifo_level      - frames stored in the FIFO
//   underrun, busy  - sticky empty-tick flag, running-with-data flag
module pdm_dac_multi #(
   parameter int DATA_W     = 24,
   parameter int CHANNELS   = 2,
   parameter int FIFO_DEPTH = 4,
   parameter int SAMPLE_DIV = 256,
   parameter int PWM_W      = 8
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           enable,
   input  logic                           mode,
   input  logic                           wr_valid,
   output logic                           wr_ready,
   input  logic [CHANNELS*DATA_W-1:0]     wr_data,
   input  logic                           clr_status,
   output logic [CHANNELS-1:0]            pdm_out,
   output logic                           sample_tick,
   output logic [$clog2(FIFO_DEPTH):0]    fifo_level,
   output logic                           underrun,
   output logic                           busy
);

   localparam int PTR_W   = $clog2(FIFO_DEPTH);
   localparam int DIV_W   = $clog2(SAMPLE_DIV);
   localparam int FRAME_W = CHANNELS * DATA_W;

   logic [FRAME_W-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0]   rd_ptr;
   logic [PTR_W-1:0]   wr_ptr;
   logic [FRAME_W-1:0] head;

   logic [DIV_W-1:0]   div_cnt;
   logic               div_last;
   logic [PWM_W-1:0]   pwm_cnt;
   logic               mode_q;
   logic               push;
   logic               pop;
   logic               empty;

   logic [DATA_W-1:0]  hold [CHANNELS];
   logic [DATA_W-1:0]  acc  [CHANNELS];
   logic [DATA_W:0]    sum  [CHANNELS];
   logic [PWM_W-1:0]   top  [CHANNELS];

   assign div_last    = (div_cnt == DIV_W'(SAMPLE_DIV - 1));
   assign sample_tick = enable & div_last;
   assign empty       = (fifo_level == '0);
   assign wr_ready    = (fifo_level != (PTR_W + 1)'(FIFO_DEPTH));
   assign push        = wr_valid & wr_ready;
   // An empty FIFO cannot pop, so a same-cycle push on empty is simply stored.
   assign pop         = sample_tick & ~empty;
   assign head        = mem[rd_ptr];

   always_comb begin
      for (int k = 0; k < CHANNELS; k++) begin
         sum[k] = {1'b0, acc[k]} + {1'b0, hold[k]};
         top[k] = hold[k][DATA_W-1 -: PWM_W];
      end
   end

   // Frame storage carries no reset; validity is tracked by the pointers.
   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         fifo_level <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)
            fifo_level <= fifo_level + 1'b1;
         else if (pop && !push)
            fifo_level <= fifo_level - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         div_cnt  <= '0;
         pwm_cnt  <= '0;
         mode_q   <= 1'b0;
         busy     <= 1'b0;
         underrun <= 1'b0;
         pdm_out  <= '0;
         for (int k = 0; k < CHANNELS; k++) begin
            hold[k] <= '0;
            acc[k]  <= '0;
         end
      end else begin
         // Set has priority over a coincident clear.
         if (sample_tick && empty)
            underrun <= 1'b1;
         else if (clr_status)
            underrun <= 1'b0;

         if (!enable) begin
            mode_q  <= mode;
            div_cnt <= '0;
            pwm_cnt <= '0;
            busy    <= 1'b0;
            pdm_out <= '0;
            for (int k = 0; k < CHANNELS; k++) begin
               hold[k] <= '0;
               acc[k]  <= '0;
            end
         end else begin
            div_cnt <= div_last ? '0 : div_cnt + 1'b1;
            pwm_cnt <= pwm_cnt + 1'b1;
            if (pop)
               busy <= 1'b1;
            for (int k = 0; k < CHANNELS; k++) begin
               if (mode_q) begin
                  pdm_out[k] <= (pwm_cnt < top[k]);
               end else begin
                  acc[k]     <= sum[k][DATA_W-1:0];
                  pdm_out[k] <= sum[k][DATA_W];
               end
               if (pop)
                  hold[k] <= head[k*DATA_W +: DATA_W];
            end
         end
      end
   end

endmodule

// File: tb/tb_pdm_dac_multi.sv
// Self-checking bench for pdm_dac_multi: directed scenarios plus random
// traffic, every cycle compared against a frame-level behavioural model.
module tb_pdm_dac_multi;

   localparam int DW  = 24;
   localparam int CH  = 2;
   localparam int DEP = 4;
   localparam int DIV = 16;
   localparam int PW  = 4;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic            enable = 1'b0;
   logic            mode = 1'b0;
   logic            wr_valid = 1'b0;
   logic            wr_ready;
   logic [CH*DW-1:0] wr_data = '0;
   logic            clr_status = 1'b0;
   logic [CH-1:0]   pdm_out;
   logic            sample_tick;
   logic [2:0]      fifo_level;
   logic            underrun;
   logic            busy;

   int n_vec = 0;
   int n_err = 0;

   // Behavioural model state
   logic [CH*DW-1:0] m_q[$];
   longint m_hold [CH];
   longint m_acc  [CH];
   bit     m_pdm  [CH];
   int     m_div, m_cnt;
   bit     m_under, m_busy, m_mode;

   int ones0, ones1;

   pdm_dac_multi #(
      .DATA_W(DW), .CHANNELS(CH), .FIFO_DEPTH(DEP),
      .SAMPLE_DIV(DIV), .PWM_W(PW)
   ) dut (
      .clk(clk), .reset(reset), .enable(enable), .mode(mode),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
      .clr_status(clr_status), .pdm_out(pdm_out),
      .sample_tick(sample_tick), .fifo_level(fifo_level),
      .underrun(underrun), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         if (n_err <= 30)
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, obs, exp, $time);
      end
   endtask

   task automatic model_clear();
      m_q.delete();
      for (int k = 0; k < CH; k++) begin
         m_hold[k] = 0;
         m_acc[k]  = 0;
         m_pdm[k]  = 0;
      end
      m_div = 0; m_cnt = 0;
      m_under = 0; m_busy = 0; m_mode = 0;
   endtask

   // One clock: check the combinational tick, advance the model,
   // then check the registered outputs just after the edge.
   task automatic step();
      logic [CH*DW-1:0] f;
      bit tick, push, pop;
      int lvl;
      longint s;
      logic [CH-1:0] exp_pdm;
      #1;
      tick = enable && (m_div == DIV - 1);
      chk("sample_tick", sample_tick, tick);
      lvl  = m_q.size();
      push = wr_valid && (lvl < DEP);
      pop  = tick && (lvl > 0);
      if (reset) begin
         model_clear();
      end else begin
         if (tick && lvl == 0)
            m_under = 1;
         else if (clr_status)
            m_under = 0;
         if (!enable) begin
            m_mode = mode;
            m_div = 0; m_cnt = 0; m_busy = 0;
            for (int k = 0; k < CH; k++) begin
               m_hold[k] = 0; m_acc[k] = 0; m_pdm[k] = 0;
            end
         end else begin
            for (int k = 0; k < CH; k++) begin
               if (m_mode) begin
                  m_pdm[k] = (m_cnt < (m_hold[k] / (2 ** (DW - PW))));
               end else begin
                  s = m_acc[k] + m_hold[k];
                  m_pdm[k] = (s >= 2 ** DW);
                  m_acc[k] = s % (2 ** DW);
               end
            end
            m_cnt = (m_cnt + 1) % (2 ** PW);
            m_div = (m_div + 1) % DIV;
            if (pop) begin
               f = m_q.pop_front();
               for (int k = 0; k < CH; k++)
                  m_hold[k] = longint'(f[k*DW +: DW]);
               m_busy = 1;
            end
         end
         if (push)
            m_q.push_back(wr_data);
      end
      @(posedge clk);
      #1;
      for (int k = 0; k < CH; k++)
         exp_pdm[k] = m_pdm[k];
      chk("pdm_out", pdm_out, exp_pdm);
      chk("fifo_level", fifo_level, m_q.size());
      chk("wr_ready", wr_ready, m_q.size() != DEP);
      chk("underrun", underrun, m_under);
      chk("busy", busy, m_busy);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++)
         step();
   endtask

   task automatic run_count(input int n);
      ones0 = 0; ones1 = 0;
      for (int i = 0; i < n; i++) begin
         step();
         ones0 += int'(pdm_out[0]);
         ones1 += int'(pdm_out[1]);
      end
   endtask

   task automatic do_reset(input int n);
      reset = 1'b1; enable = 1'b0; wr_valid = 1'b0; clr_status = 1'b0;
      run(n);
      reset = 1'b0;
   endtask

   initial begin
      model_clear();
      // Reset state
      do_reset(3);
      chk("rst_pdm", pdm_out, 0);
      chk("rst_level", fifo_level, 0);
      chk("rst_ready", wr_ready, 1);
      chk("rst_under", underrun, 0);

      // Delta-sigma density
      mode = 1'b0;
      wr_data = {24'h400000, 24'h800000};
      wr_valid = 1'b1;
      run(1);
      enable = 1'b1;
      run(3);
      wr_valid = 1'b0;
      run(20);
      run_count(16);
      chk("ds_ch0_ones", ones0, 8);
      chk("ds_ch1_ones", ones1, 4);
      chk("ds_busy", busy, 1);

      // PWM mode, mode change while enabled ignored
      do_reset(2);
      mode = 1'b1;
      wr_data = {24'h000000, 24'h400000};
      wr_valid = 1'b1;
      run(1);
      wr_valid = 1'b0;
      enable = 1'b1;
      run(20);
      mode = 1'b0;
      run_count(16);
      chk("pwm_ch0_high", ones0, 4);
      chk("pwm_ch1_high", ones1, 0);

      // FIFO full / backpressure
      do_reset(2);
      for (int i = 0; i < 5; i++) begin
         wr_data = {$urandom, $urandom};
         wr_valid = 1'b1;
         run(1);
      end
      chk("full_level", fifo_level, 4);
      chk("full_ready", wr_ready, 0);
      wr_valid = 1'b0;
      enable = 1'b1;
      run(16);
      chk("pop_level", fifo_level, 3);
      chk("pop_ready", wr_ready, 1);

      // Underrun
      do_reset(2);
      mode = 1'b0;
      wr_data = {24'h200000, 24'hC00000};
      wr_valid = 1'b1;
      run(1);
      wr_valid = 1'b0;
      enable = 1'b1;
      run(16);
      chk("ur_first", underrun, 0);
      run(16);
      chk("ur_second", underrun, 1);
      run(16);
      clr_status = 1'b1;
      run(1);
      clr_status = 1'b0;
      chk("ur_cleared", underrun, 0);
      run(14);
      clr_status = 1'b1;
      run(1);
      clr_status = 1'b0;
      chk("ur_set_wins", underrun, 1);

      // Reset mid-operation
      do_reset(2);
      wr_data = {24'h555555, 24'hAAAAAA};
      wr_valid = 1'b1;
      run(3);
      wr_valid = 1'b0;
      enable = 1'b1;
      run(20);
      reset = 1'b1;
      run(1);
      chk("mid_level", fifo_level, 0);
      chk("mid_pdm", pdm_out, 0);
      chk("mid_under", underrun, 0);
      reset = 1'b0; enable = 1'b0;
      wr_data = {24'h100000, 24'h800000};
      wr_valid = 1'b1;
      run(1);
      wr_valid = 1'b0;
      enable = 1'b1;
      run(40);

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         reset = ($urandom_range(0, 999) < 3);
         if ($urandom_range(0, 99) < 2)
            enable = ~enable;
         mode = 1'($urandom);
         wr_valid = 1'($urandom);
         case ($urandom_range(0, 3))
            0: wr_data = '0;
            1: wr_data = '1;
            default: wr_data = {$urandom, $urandom};
         endcase
         clr_status = ($urandom_range(0, 99) < 3);
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
